// File: rtl/cache_if_pkg.sv
// Shared cache/memory interface definitions: request type codes, line geometry
// and the memory responder state encoding.
package cache_if_pkg;

  localparam logic [2:0] RT_BYTE = 3'd0;
  localparam logic [2:0] RT_HALF = 3'd1;
  localparam logic [2:0] RT_WORD = 3'd2;
  localparam logic [2:0] RT_LINE = 3'd4;

  localparam int WORD_W     = 32;
  localparam int LINE_W     = 128;
  localparam int LINE_WORDS = LINE_W / WORD_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } resp_state_e;

endpackage

// File: rtl/mem_bank.sv
// 32-bit single-port RAM with synchronous read and per-byte write enables.
module mem_bank #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  // Zero contents give the simulation model a defined power-up state.
  logic [31:0] mem [2**AW] = '{default: '0};

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder for cache refills and write-backs: four word banks,
// in-order read beats after an optional fixed latency, writes commit in IDLE.
module cache_mem_responder #(
  parameter int LINE_AW  = 8,
  parameter int READ_LAT = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy
);

  import cache_if_pkg::*;

  resp_state_e        state;
  logic [LINE_AW-1:0] line_q;
  logic [1:0]         word_q;
  logic [2:0]         beats_q;
  logic [3:0]         lat_cnt;

  logic               idle, wr_go, rd_go, rd_line, wr_line;
  logic [1:0]         start_word;
  logic               iss, iss_last;
  logic [1:0]         iss_word;

  logic               bank_en;
  logic [LINE_AW-1:0] bank_addr;
  logic [3:0]         bank_we    [LINE_WORDS];
  logic [WORD_W-1:0]  bank_wdata [LINE_WORDS];
  logic [WORD_W-1:0]  bank_q     [LINE_WORDS];

  logic               vld_p1, last_p1;
  logic [1:0]         sel_p1;

  logic               unused_addr_bits;
  assign unused_addr_bits = ^{rd_addr[31:LINE_AW+4], rd_addr[1:0],
                              wr_addr[31:LINE_AW+4], wr_addr[1:0]};

  // Request handshake: writes win a simultaneous request in IDLE.
  assign idle       = (state == ST_IDLE);
  assign wr_rdy     = idle && !reset;
  assign rd_rdy     = wr_rdy && !wr_req;
  assign wr_go      = wr_req && wr_rdy;
  assign rd_go      = rd_req && rd_rdy;
  assign rd_line    = (rd_type == RT_LINE);
  assign wr_line    = (wr_type == RT_LINE);
  assign start_word = rd_line ? 2'd0 : rd_addr[3:2];

  // Bank reads are issued one cycle ahead of the beat they feed.
  always_comb begin
    iss      = 1'b0;
    iss_last = 1'b0;
    iss_word = word_q;
    case (state)
      ST_IDLE: begin
        if (rd_go && READ_LAT == 0) begin
          iss      = 1'b1;
          iss_word = start_word;
          iss_last = !rd_line;
        end
      end
      ST_WAIT: begin
        if (lat_cnt == 4'd1) begin
          iss      = 1'b1;
          iss_word = word_q;
          iss_last = (beats_q == 3'd1);
        end
      end
      ST_BURST: begin
        if (beats_q > 3'd1) begin
          iss      = 1'b1;
          iss_word = word_q + 2'd1;
          iss_last = (beats_q == 3'd2);
        end
      end
      default: ;
    endcase
  end

  assign bank_en   = wr_go || iss;
  assign bank_addr = wr_go ? wr_addr[LINE_AW+3:4] :
                     idle  ? rd_addr[LINE_AW+3:4] : line_q;

  for (genvar k = 0; k < LINE_WORDS; k++) begin : g_bank
    assign bank_we[k]    = !wr_go  ? 4'h0 :
                           wr_line ? 4'hF :
                           (wr_addr[3:2] == 2'(k)) ? wr_wstrb : 4'h0;
    assign bank_wdata[k] = wr_line ? wr_data[WORD_W*k +: WORD_W] : wr_data[WORD_W-1:0];

    mem_bank #(.AW(LINE_AW)) u_bank (
      .clk   (clk),
      .en    (bank_en),
      .we    (bank_we[k]),
      .addr  (bank_addr),
      .wdata (bank_wdata[k]),
      .rdata (bank_q[k])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      beats_q <= 3'd0;
      lat_cnt <= 4'd0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= iss;
      last_p1 <= iss && iss_last;
      case (state)
        ST_IDLE: begin
          if (rd_go) begin
            line_q  <= rd_addr[LINE_AW+3:4];
            word_q  <= start_word;
            beats_q <= rd_line ? 3'd4 : 3'd1;
            if (READ_LAT == 0) begin
              state <= ST_BURST;
            end else begin
              state   <= ST_WAIT;
              lat_cnt <= 4'(READ_LAT);
            end
          end
        end
        ST_WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt == 4'd1) state <= ST_BURST;
        end
        ST_BURST: begin
          if (beats_q == 3'd1) begin
            state <= ST_IDLE;
          end else begin
            beats_q <= beats_q - 3'd1;
            word_q  <= word_q + 2'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
    sel_p1 <= iss_word;
  end

  // Stage p1: synchronous bank outputs steered to the return port.
  assign ret_valid = vld_p1;
  assign ret_last  = last_p1;
  assign ret_data  = vld_p1 ? bank_q[sel_p1] : '0;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Self-checking bench: two responders (READ_LAT 0 and 3) share stimulus and
// are checked cycle by cycle against a word-array memory model.
module tb_cache_mem_responder;

  localparam int NDUT = 2;
  localparam int LAT [NDUT] = '{0, 3};

  logic         clk = 1'b0;
  logic         reset;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;

  logic [NDUT-1:0] rd_rdy, wr_rdy, ret_valid, ret_last;
  logic [31:0]     ret_data [NDUT];

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [256][4];

  always #5 clk = ~clk;

  cache_mem_responder #(.LINE_AW(8), .READ_LAT(0)) u_lat0 (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy[0]),
    .ret_valid(ret_valid[0]), .ret_last(ret_last[0]), .ret_data(ret_data[0]),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy[0])
  );

  cache_mem_responder #(.LINE_AW(8), .READ_LAT(3)) u_lat3 (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy[1]),
    .ret_valid(ret_valid[1]), .ret_last(ret_last[1]), .ret_data(ret_data[1]),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy[1])
  );

  task automatic mdl_write(input logic [31:0] addr, input logic [2:0] typ,
                           input logic [3:0] strb, input logic [127:0] data);
    int li;
    int w;
    li = int'(addr[11:4]);
    if (typ == 3'd4) begin
      for (int k = 0; k < 4; k++) mdl[li][k] = data[32*k +: 32];
    end else begin
      w = int'(addr[3:2]);
      for (int b = 0; b < 4; b++)
        if (strb[b]) mdl[li][w][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [2:0] typ,
                    input logic [3:0] strb, input logic [127:0] data);
    wr_req = 1'b1; wr_addr = addr; wr_type = typ; wr_wstrb = strb; wr_data = data;
    @(negedge clk);
    checks++;
    if (wr_rdy !== 2'b11) begin
      errors++;
      $display("FAIL wr_rdy addr=%h: got %b required 11", addr, wr_rdy);
    end
    @(posedge clk); #1;
    wr_req = 1'b0;
    mdl_write(addr, typ, strb, data);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [2:0] typ);
    logic [31:0] exp_w [4];
    int n;
    logic ev, el, er;
    n = (typ == 3'd4) ? 4 : 1;
    for (int k = 0; k < 4; k++)
      exp_w[k] = (typ == 3'd4) ? mdl[int'(addr[11:4])][k] : mdl[int'(addr[11:4])][int'(addr[3:2])];
    rd_req = 1'b1; rd_addr = addr; rd_type = typ;
    @(negedge clk);
    checks++;
    if (rd_rdy !== 2'b11) begin
      errors++;
      $display("FAIL rd_accept addr=%h: rd_rdy got %b required 11", addr, rd_rdy);
    end
    @(posedge clk); #1;
    rd_req = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        ev = (c > LAT[d]) && (c <= LAT[d] + n);
        el = (c == LAT[d] + n);
        er = (c > LAT[d] + n);
        checks++;
        if (ret_valid[d] !== ev || ret_last[d] !== el || rd_rdy[d] !== er) begin
          errors++;
          $display("FAIL rd_ctl dut_lat%0d addr=%h cycle %0d: valid/last/rdy got %b%b%b required %b%b%b",
                   LAT[d], addr, c, ret_valid[d], ret_last[d], rd_rdy[d], ev, el, er);
        end
        if (ev) begin
          checks++;
          if (ret_data[d] !== exp_w[c - LAT[d] - 1]) begin
            errors++;
            $display("FAIL rd_data dut_lat%0d addr=%h beat %0d: got %h required %h",
                     LAT[d], addr, c - LAT[d] - 1, ret_data[d], exp_w[c - LAT[d] - 1]);
          end
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (rd_rdy[d] !== 1'b0 || wr_rdy[d] !== 1'b0 || ret_valid[d] !== 1'b0 ||
          ret_last[d] !== 1'b0 || ret_data[d] !== 32'h0) begin
        errors++;
        $display("FAIL reset_vals dut_lat%0d: rd_rdy=%b wr_rdy=%b valid=%b last=%b data=%h required all zero",
                 LAT[d], rd_rdy[d], wr_rdy[d], ret_valid[d], ret_last[d], ret_data[d]);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_rdy !== 2'b11 || wr_rdy !== 2'b11) begin
      errors++;
      $display("FAIL reset_release: rd_rdy=%b wr_rdy=%b required 11 11", rd_rdy, wr_rdy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_line_rw();
    wr(32'h0000_1230, 3'd4, 4'h0, 128'h44444444_33333333_22222222_11111111);
    rd(32'h0000_1238, 3'd4);
  endtask

  task automatic test_byte_strobe();
    wr(32'h0000_1234, 3'd0, 4'b0010, {96'h0, 32'h0000AB00});
    rd(32'h0000_1234, 3'd2);
    wr(32'h0000_1238, 3'd2, 4'b0000, {96'h0, 32'hDEADBEEF});
    rd(32'h0000_1238, 3'd2);
    wr(32'h0000_123C, 3'd1, 4'b1100, {96'h0, 32'hCAFE0000});
    rd(32'h0000_1230, 3'd4);
  endtask

  task automatic test_back_to_back();
    wr(32'h0000_0200, 3'd4, 4'h0, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0);
    wr(32'h0000_0208, 3'd2, 4'hF, {96'h0, 32'h12345678});
    wr(32'h0000_0210, 3'd4, 4'h0, 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0);
    rd(32'h0000_0200, 3'd4);
    rd(32'h0000_0214, 3'd2);
  endtask

  task automatic test_simultaneous();
    wr_req = 1'b1; wr_addr = 32'h0000_0340; wr_type = 3'd4; wr_wstrb = 4'h0;
    wr_data = 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A;
    rd_req = 1'b1; rd_addr = 32'h0000_0340; rd_type = 3'd4;
    @(negedge clk);
    checks++;
    if (wr_rdy !== 2'b11 || rd_rdy !== 2'b00) begin
      errors++;
      $display("FAIL simul_prio: wr_rdy=%b rd_rdy=%b required 11 00", wr_rdy, rd_rdy);
    end
    @(posedge clk); #1;
    wr_req = 1'b0;
    mdl_write(32'h0000_0340, 3'd4, 4'h0, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A);
    rd(32'h0000_0340, 3'd4);
  endtask

  task automatic test_alias();
    wr(32'h0000_0010, 3'd4, 4'h0, 128'h9999AAAA_7777BBBB_5555CCCC_3333DDDD);
    rd(32'h0000_1010, 3'd4);
    rd(32'hFFFF_F01C, 3'd2);
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] w1;
    w1 = mdl[8'h23][1];
    rd_req = 1'b1; rd_addr = 32'h0000_0230; rd_type = 3'd4;
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(negedge clk);
    checks++;
    if (ret_valid !== 2'b01) begin
      errors++;
      $display("FAIL midrst_beat1: ret_valid got %b required 01", ret_valid);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (ret_valid !== 2'b01 || ret_data[0] !== w1 || rd_rdy !== 2'b00) begin
      errors++;
      $display("FAIL midrst_beat2: valid=%b data=%h rd_rdy=%b required 01 %h 00",
               ret_valid, ret_data[0], rd_rdy, w1);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 3; c <= 10; c++) begin
      @(negedge clk);
      checks++;
      if (ret_valid !== 2'b00 || rd_rdy !== 2'b11) begin
        errors++;
        $display("FAIL midrst_after cycle %0d: ret_valid=%b rd_rdy=%b required 00 11",
                 c, ret_valid, rd_rdy);
      end
      @(posedge clk); #1;
    end
    rd(32'h0000_0230, 3'd4);
  endtask

  task automatic test_random();
    logic [7:0]  pool [4];
    logic [31:0] a;
    logic [127:0] d;
    logic [2:0]  t;
    pool = '{8'h05, 8'h23, 8'h7F, 8'hC4};
    for (int i = 0; i < 40; i++) begin
      a = $urandom();
      a[11:4] = pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 9) < 6) begin
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        case ($urandom_range(0, 3))
          0: t = 3'd0;
          1: t = 3'd1;
          2: t = 3'd2;
          default: t = 3'd4;
        endcase
        wr(a, t, 4'($urandom()), d);
      end else begin
        t = 3'($urandom());
        rd(a, t);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      for (int k = 0; k < 4; k++) mdl[i][k] = 32'h0;
    reset = 1'b1; rd_req = 1'b0; rd_type = 3'd0; rd_addr = 32'h0;
    wr_req = 1'b0; wr_type = 3'd0; wr_addr = 32'h0; wr_wstrb = 4'h0; wr_data = 128'h0;
    test_reset();
    test_line_rw();
    test_byte_strobe();
    test_back_to_back();
    test_simultaneous();
    test_alias();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
    $fatal(1, "time limit");
  end

endmodule
